// File: rtl/bridge_pkg.sv
// bridge_pkg: shared FSM states and AXI response codes for the AXI-Lite BRAM bridge
package bridge_pkg;
  typedef enum logic [2:0] {IDLE, WR_EXEC, WR_RESP, RD_ADDR, RD_CAP, RD_RESP} bridge_state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_bram_bridge.sv
// axi_lite_bram_bridge: AXI4-Lite slave turning single-beat transactions into shared BRAM port accesses
module axi_lite_bram_bridge
  import bridge_pkg::*;
#(
  parameter int AXI_AW = 16,
  parameter int SIZE = 1024,
  parameter int NUM_COL = 4,
  localparam int LOGSIZE = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AXI_AW-1:0]    s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [NUM_COL-1:0]   s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [AXI_AW-1:0]    s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic [31:0]          bram_din,
  output logic [LOGSIZE+2:0]   shared_bram_addr,
  output logic [NUM_COL-1:0]   bram_wr_en,
  input  logic [31:0]          bram_dout
);
  localparam int BW = LOGSIZE + 3;
  bridge_state_t state, state_nx;
  logic live, aw_held, w_held, prio_wr;
  logic [AXI_AW-1:0] aw_addr, ar_addr;
  logic [31:0] w_data;
  logic [NUM_COL-1:0] w_strb;
  logic idle, wr_full, wr_soon, aw_hs, w_hs, ar_hs, aw_oob, ar_oob, wr, rd;
  assign idle = live && state == IDLE;
  assign wr_full = aw_held && w_held;
  // a write counts as contending as soon as both halves are present, held or arriving
  assign wr_soon = (aw_held || s_axi_awvalid) && (w_held || s_axi_wvalid);
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign aw_oob = (aw_addr >> BW) != '0;
  assign ar_oob = (ar_addr >> BW) != '0;
  assign wr = state == WR_EXEC;
  assign rd = state == RD_ADDR || state == RD_CAP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ar_hs ? RD_ADDR : wr_full ? WR_EXEC : IDLE;
      WR_EXEC: state_nx = WR_RESP;
      WR_RESP: state_nx = s_axi_bready ? IDLE : WR_RESP;
      RD_ADDR: state_nx = RD_CAP;
      RD_CAP:  state_nx = RD_RESP;
      RD_RESP: state_nx = s_axi_rready ? IDLE : RD_RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = idle && !aw_held;
    s_axi_wready = idle && !w_held;
    s_axi_arready = idle && !(prio_wr && wr_soon);
    s_axi_bvalid = state == WR_RESP;
    s_axi_rvalid = state == RD_RESP;
    shared_bram_addr = wr ? aw_addr[BW-1:0] : rd ? ar_addr[BW-1:0] : '0;
    bram_din = wr ? w_data : '0;
    bram_wr_en = (wr && !aw_oob) ? w_strb : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      prio_wr <= 1'b1;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rdata <= '0;
    end else begin
      live <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (ar_hs) ar_addr <= s_axi_araddr;
      // priority flips only when it actually decided between a waiting write and read
      if (idle && wr_soon && s_axi_arvalid) prio_wr <= ar_hs ? 1'b1 : wr_full ? 1'b0 : prio_wr;
      if (wr) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s_axi_bresp <= aw_oob ? RESP_SLVERR : RESP_OKAY;
      end
      if (state == RD_CAP) begin
        s_axi_rdata <= ar_oob ? '0 : bram_dout;
        s_axi_rresp <= ar_oob ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_bram_bridge.sv
// tb_axi_lite_bram_bridge: scoreboard bench with a word-array reference model and a BRAM stand-in
module tb_axi_lite_bram_bridge;
  localparam int AW = 16;
  localparam int BW = 13;
  logic clk = 0, reset = 1;
  logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, bram_din, bram_dout;
  logic [BW-1:0] shared_bram_addr;
  logic [3:0] bram_wr_en;
  always #5 clk = ~clk;

  axi_lite_bram_bridge #(.AXI_AW(AW), .SIZE(1024), .NUM_COL(4)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .bram_din(bram_din), .shared_bram_addr(shared_bram_addr), .bram_wr_en(bram_wr_en), .bram_dout(bram_dout)
  );

  wire [89:0] outs = {s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready, s_axi_rdata,
                      s_axi_rresp, s_axi_rvalid, bram_din, shared_bram_addr, bram_wr_en};

  logic [31:0] mem [0:2047];
  logic [31:0] ref_mem [0:2047];
  int compared = 0, mismatched = 0, cyc = 0, pulses = 0, pulse_cyc = 0, bv_cyc = 0;
  int aw_cyc = 0, w_cyc = 0;
  logic [BW-1:0] last_addr = '0;
  logic [3:0] last_en = '0;
  logic bv_prev = 0, rstall = 0, rdy_run = 0;
  logic [33:0] rhold = '0;
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  logic order[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // processor-side BRAM: registered read, byte-enabled write
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bram_wr_en[b]) mem[shared_bram_addr[BW-1:2]][8*b+:8] <= bram_din[8*b+:8];
    bram_dout <= mem[shared_bram_addr[BW-1:2]];
  end

  always @(negedge clk) begin
    if (bram_wr_en != 0) begin
      pulses++;
      pulse_cyc = cyc;
      last_addr = shared_bram_addr;
      last_en = bram_wr_en;
    end
    if (s_axi_bvalid && !bv_prev) bv_cyc = cyc;
    bv_prev = s_axi_bvalid;
    if (rstall && s_axi_rvalid) chk("r_stable", {s_axi_rresp, s_axi_rdata}, rhold);
    rstall = s_axi_rvalid && !s_axi_rready;
    rhold = {s_axi_rresp, s_axi_rdata};
    if (s_axi_bvalid && s_axi_bready) begin
      order.push_back(1'b1);
      chk("b_expected", bq.size() != 0, 1);
      if (bq.size() != 0) chk("bresp", s_axi_bresp, bq.pop_front());
    end
    if (s_axi_rvalid && s_axi_rready) begin
      order.push_back(1'b0);
      chk("r_expected", rq.size() != 0, 1);
      if (rq.size() != 0) chk("rresp_rdata", {s_axi_rresp, s_axi_rdata}, rq.pop_front());
    end
  end

  function automatic logic is_oob(input logic [AW-1:0] a);
    return (a >> BW) != 0;
  endfunction

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    bq.push_back(is_oob(a) ? 2'b10 : 2'b00);
    if (!is_oob(a))
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[BW-1:2]][8*b+:8] = d[8*b+:8];
  endtask

  task automatic expect_read(input logic [AW-1:0] a);
    rq.push_back(is_oob(a) ? {2'b10, 32'h0} : {2'b00, ref_mem[a[BW-1:2]]});
  endtask

  task automatic send_aw(input logic [AW-1:0] a, input int dly);
    int n;
    n = 0;
    repeat (dly) @(posedge clk);
    #1 s_axi_awaddr = a;
    s_axi_awvalid = 1;
    do begin @(negedge clk); n++; end while (!s_axi_awready && n < 200);
    chk("aw_accept", s_axi_awready, 1);
    @(posedge clk);
    #1 aw_cyc = cyc;
    s_axi_awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n;
    n = 0;
    repeat (dly) @(posedge clk);
    #1 s_axi_wdata = d;
    s_axi_wstrb = s;
    s_axi_wvalid = 1;
    do begin @(negedge clk); n++; end while (!s_axi_wready && n < 200);
    chk("w_accept", s_axi_wready, 1);
    @(posedge clk);
    #1 w_cyc = cyc;
    s_axi_wvalid = 0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a, input int dly);
    int n;
    n = 0;
    repeat (dly) @(posedge clk);
    #1 s_axi_araddr = a;
    s_axi_arvalid = 1;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 200);
    chk("ar_accept", s_axi_arready, 1);
    @(posedge clk);
    #1 s_axi_arvalid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin @(posedge clk); n++; end
    chk("resp_drain", bq.size() + rq.size(), 0);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int daw, input int dw);
    expect_write(a, d, s);
    fork
      send_aw(a, daw);
      send_w(d, s, dw);
    join
    wait_done();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int dly);
    expect_read(a);
    send_ar(a, dly);
    wait_done();
  endtask

  task automatic do_reset();
    reset = 0;
    {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid} = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'(($urandom_range(0, 3) << 11) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) a = a | AW'(1 << $urandom_range(BW, AW - 1));
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int p0, rv;
    logic [AW-1:0] a;
    for (int i = 0; i < 2048; i++) begin
      ref_mem[i] = $urandom;
      mem[i] = ref_mem[i];
    end
    #1 reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 s_axi_awaddr = AW'($urandom);
      s_axi_araddr = AW'($urandom);
      s_axi_wdata = $urandom;
      s_axi_wstrb = 4'($urandom);
      {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready} = 5'($urandom);
      @(negedge clk);
      chk("reset_outputs_zero", outs, 0);
    end
    {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready} = '0;
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    @(posedge clk);
    #1 s_axi_bready = 1;
    s_axi_rready = 1;
    p0 = pulses;
    do_write(16'h0004, 32'hDEADBEEF, 4'hF, 0, 0);
    chk("t2_pulse_count", pulses - p0, 1);
    chk("t2_addr", last_addr, 13'h004);
    chk("t2_wr_en", last_en, 4'hF);
    chk("t2_b_latency", bv_cyc - aw_cyc, 2);
    p0 = pulses;
    do_write(16'h0010, 32'h0000AB00, 4'b0010, 3, 0);
    chk("t3_pulse_count", pulses - p0, 1);
    chk("t3_wr_en", last_en, 4'b0010);
    chk("t3_pulse_after_aw", pulse_cyc - aw_cyc, 1);
    do_read(16'h0010, 0);
    do_read(16'h0004, 0);
    a = AW'((1 << 12) | 8);
    mem[a[BW-1:2]] = 32'h12345678;
    ref_mem[a[BW-1:2]] = 32'h12345678;
    s_axi_rready = 0;
    fork
      do_read(a, 0);
      begin
        repeat (9) @(posedge clk);
        #1 s_axi_rready = 1;
      end
    join
    do_reset();
    order.delete();
    expect_write(16'h0040, 32'hCAFEF00D, 4'hF);
    expect_read(16'h0044);
    fork
      send_aw(16'h0040, 0);
      send_w(32'hCAFEF00D, 4'hF, 0);
      send_ar(16'h0044, 0);
    join
    wait_done();
    expect_write(16'h0048, 32'h0BADF00D, 4'hF);
    expect_read(16'h0040);
    fork
      send_aw(16'h0048, 0);
      send_w(32'h0BADF00D, 4'hF, 0);
      send_ar(16'h0040, 0);
    join
    wait_done();
    chk("t5_order", {order.size() == 4, order[0], order[1], order[2], order[3]}, 5'b11001);
    p0 = pulses;
    do_write(16'h2020, 32'h55AA55AA, 4'hF, 0, 1);
    chk("t6_oob_no_wr_en", pulses - p0, 0);
    do_read(16'h0020, 0);
    do_read(16'h8004, 0);
    do_write(16'h0030, 32'h11223344, 4'h0, 1, 0);
    do_read(16'h0030, 0);
    send_ar(16'h0004, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("t6_reset_in_rd_cap", outs, 0);
    @(posedge clk);
    #1 reset = 1;
    rv = 0;
    repeat (10) begin
      @(negedge clk);
      rv += int'(s_axi_rvalid);
    end
    chk("t6_no_r_after_reset", rv, 0);
    chk("t6_idle_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    @(posedge clk);
    #1 send_w(32'h99999999, 4'hF, 0);
    do_reset();
    p0 = pulses;
    expect_write(16'h0050, 32'h77665544, 4'hF);
    send_aw(16'h0050, 0);
    repeat (5) @(posedge clk);
    #1 chk("stale_w_discarded", pulses - p0, 0);
    send_w(32'h77665544, 4'hF, 0);
    wait_done();
    do_read(16'h0050, 0);
    rdy_run = 1;
    fork
      while (rdy_run) begin
        @(posedge clk);
        #1 s_axi_bready = $urandom_range(0, 2) != 0;
        s_axi_rready = $urandom_range(0, 2) != 0;
      end
    join_none
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(rand_addr(), $urandom_range(0, 2));
    end
    rdy_run = 0;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
